prbs_lfsr_gen: RTL and testbench

Parametrised Galois-LFSR pseudo-random bit sequence generator with width, polynomial and seed set by parameters. A clock-enable tick divider replaces the derived-clock scheme: all state runs on the single master clock. Adds runtime seed load, zero-seed guard, single-bit error injection for checker testing, and period measurement. Sits between the master-clock domain and PRBS consumers (serial test links, BER checkers, LED/IO test patterns).

---
 rtl/prbs_lfsr_gen.sv | 91 +++++++++
 tb/tb_prbs_lfsr_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/prbs_lfsr_gen.sv
// Galois-LFSR PRBS generator on a single master clock, advanced by a clock-enable tick divider.
// Adds runtime seed load with a zero-seed guard, one-shot error injection and period measurement.
module prbs_lfsr_gen #(
  parameter int unsigned    W     = 8,
  parameter logic [W-1:0]   POLY  = 8'h1C,
  parameter logic [W-1:0]   SEED  = 8'hFF,
  parameter int unsigned    DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [W-1:0]     seed,
  input  logic             inject_err,
  output logic             prbs,
  output logic             prbs_valid,
  output logic [W-1:0]     state,
  output logic             period_start,
  output logic [W-1:0]     period_len
);

  logic [DIV_W-1:0] div_cnt;
  logic [W-1:0]     ref_seed;
  logic [W-1:0]     adv_cnt;
  logic             err_pending;

  logic             tick;
  logic             fb;
  logic [W-1:0]     nxt;
  logic [W-1:0]     ld_val;

  // The >= compare lets a lowered threshold take effect on the very next enabled cycle.
  assign tick   = en && (div_cnt >= div);
  assign ld_val = (seed == '0) ? SEED : seed;

  always_comb begin
    fb     = state[W-1];
    nxt    = '0;
    nxt[0] = fb;
    for (int i = 1; i < W; i++) begin
      nxt[i] = state[i-1] ^ (POLY[i] & fb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEED;
      ref_seed     <= SEED;
      div_cnt      <= '0;
      adv_cnt      <= '0;
      err_pending  <= 1'b0;
      prbs         <= SEED[W-1];
      prbs_valid   <= 1'b0;
      period_start <= 1'b0;
      period_len   <= '0;
    end else if (load) begin
      state        <= ld_val;
      ref_seed     <= ld_val;
      prbs         <= ld_val[W-1];
      div_cnt      <= '0;
      adv_cnt      <= '0;
      err_pending  <= 1'b0;
      prbs_valid   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      prbs_valid   <= 1'b0;
      period_start <= 1'b0;
      if (en) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
      if (tick) begin
        // A request raised in the tick cycle itself still lands on this advance.
        state       <= nxt;
        prbs        <= nxt[W-1] ^ (err_pending | inject_err);
        err_pending <= 1'b0;
        prbs_valid  <= 1'b1;
        if (nxt == ref_seed) begin
          period_start <= 1'b1;
          period_len   <= adv_cnt + 1'b1;
          adv_cnt      <= '0;
        end else begin
          adv_cnt <= adv_cnt + 1'b1;
        end
      end else begin
        err_pending <= err_pending | inject_err;
      end
    end
  end

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Directed bench for prbs_lfsr_gen: hand-computed state sequence, divider timing,
// seed load, error injection and reset priority.
module tb_prbs_lfsr_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] div;
  logic        load;
  logic [7:0]  seed;
  logic        inject_err;
  logic        prbs;
  logic        prbs_valid;
  logic [7:0]  state;
  logic        period_start;
  logic [7:0]  period_len;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] m_state;
  logic [7:0] m_ref;
  logic       m_prbs;

  // First advances from FF with POLY 1C, worked by hand.
  logic [7:0] exp_seq [5] = '{8'hE3, 8'hDB, 8'hAB, 8'h4B, 8'h96};

  prbs_lfsr_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div          (div),
    .load         (load),
    .seed         (seed),
    .inject_err   (inject_err),
    .prbs         (prbs),
    .prbs_valid   (prbs_valid),
    .state        (state),
    .period_start (period_start),
    .period_len   (period_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial x^8+x^4+x^3+x^2+1 written as a left shift with conditional XOR.
  function automatic logic [7:0] model_next(input logic [7:0] s);
    return (s << 1) ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare every output against the tracked model.
  task automatic applyStimulus(input string tag, input bit exp_valid, input bit exp_inv);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(prbs_valid), 32'(exp_valid));
    if (exp_valid) begin
      m_state = model_next(m_state);
      m_prbs  = m_state[7] ^ exp_inv;
    end
    checkOutput({tag, "_state"}, 32'(state), 32'(m_state));
    checkOutput({tag, "_prbs"}, 32'(prbs), 32'(m_prbs));
    checkOutput({tag, "_pstart"}, 32'(period_start), 32'(exp_valid && (m_state == m_ref)));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 16'd0; load = 1'b0; seed = 8'h00; inject_err = 1'b0;

    // Reset values
    @(posedge clk);
    #1;
    checkOutput("rst_state", 32'(state), 32'h0000_00FF);
    checkOutput("rst_prbs", 32'(prbs), 32'd1);
    checkOutput("rst_valid", 32'(prbs_valid), 32'd0);
    checkOutput("rst_pstart", 32'(period_start), 32'd0);
    checkOutput("rst_plen", 32'(period_len), 32'd0);
    m_state = 8'hFF; m_ref = 8'hFF; m_prbs = 1'b1;

    // Free run, one advance per cycle
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("run", 1'b1, 1'b0);
      checkOutput("run_seq", 32'(state), 32'(exp_seq[i]));
    end
    for (int i = 6; i <= 255; i++) applyStimulus("run", 1'b1, 1'b0);
    checkOutput("period1_state", 32'(state), 32'h0000_00FF);
    checkOutput("period1_len", 32'(period_len), 32'd255);
    for (int i = 1; i <= 255; i++) applyStimulus("run2", 1'b1, 1'b0);
    checkOutput("period2_len", 32'(period_len), 32'd255);

    // Divider: tick every 4th cycle
    div = 16'd3;
    for (int i = 0; i < 8; i++) applyStimulus("div3", (i % 4) == 3, 1'b0);
    applyStimulus("div3_pre", 1'b0, 1'b0);
    applyStimulus("div3_pre", 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus("hold", 1'b0, 1'b0);
    en = 1'b1;
    applyStimulus("resume", 1'b0, 1'b0);
    applyStimulus("resume", 1'b1, 1'b0);
    applyStimulus("lower", 1'b0, 1'b0);
    applyStimulus("lower", 1'b0, 1'b0);
    div = 16'd0;
    applyStimulus("lower_tick", 1'b1, 1'b0);

    // Seed load concurrent with a tick
    load = 1'b1; seed = 8'h01;
    @(posedge clk);
    #1;
    checkOutput("load_state", 32'(state), 32'h0000_0001);
    checkOutput("load_valid", 32'(prbs_valid), 32'd0);
    checkOutput("load_prbs", 32'(prbs), 32'd0);
    checkOutput("load_plen", 32'(period_len), 32'd255);
    m_state = 8'h01; m_ref = 8'h01; m_prbs = 1'b0;
    load = 1'b0;
    applyStimulus("load_adv", 1'b1, 1'b0);
    checkOutput("load_next", 32'(state), 32'h0000_0002);
    for (int i = 2; i <= 255; i++) applyStimulus("load_run", 1'b1, 1'b0);
    checkOutput("load_period", 32'(period_len), 32'd255);

    // Zero seed falls back to the reset seed
    load = 1'b1; seed = 8'h00;
    @(posedge clk);
    #1;
    checkOutput("zload_state", 32'(state), 32'h0000_00FF);
    checkOutput("zload_prbs", 32'(prbs), 32'd1);
    m_state = 8'hFF; m_ref = 8'hFF; m_prbs = 1'b1;
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("zload", 1'b1, 1'b0);
      checkOutput("zload_seq", 32'(state), 32'(exp_seq[i]));
    end

    // Error injection with div=3, phase restarted by a load
    load = 1'b1; seed = 8'h00; div = 16'd3;
    @(posedge clk);
    #1;
    m_state = 8'hFF; m_ref = 8'hFF; m_prbs = 1'b1;
    load = 1'b0;
    applyStimulus("inj_a", 1'b0, 1'b0);
    inject_err = 1'b1;
    applyStimulus("inj_a", 1'b0, 1'b0);
    inject_err = 1'b0;
    applyStimulus("inj_a", 1'b0, 1'b0);
    applyStimulus("inj_a", 1'b1, 1'b1);
    checkOutput("inj_a_bit", 32'(prbs), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus("inj_b", 1'b0, 1'b0);
    applyStimulus("inj_b", 1'b1, 1'b0);
    inject_err = 1'b1;
    applyStimulus("inj_two", 1'b0, 1'b0);
    inject_err = 1'b0;
    applyStimulus("inj_two", 1'b0, 1'b0);
    inject_err = 1'b1;
    applyStimulus("inj_two", 1'b0, 1'b0);
    inject_err = 1'b0;
    applyStimulus("inj_two", 1'b1, 1'b1);
    checkOutput("inj_two_state", 32'(state), 32'h0000_00AB);
    for (int i = 0; i < 3; i++) applyStimulus("inj_c", 1'b0, 1'b0);
    applyStimulus("inj_c", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("inj_tick", 1'b0, 1'b0);
    inject_err = 1'b1;
    applyStimulus("inj_tick", 1'b1, 1'b1);
    inject_err = 1'b0;
    checkOutput("inj_tick_bit", 32'(prbs), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus("inj_d", 1'b0, 1'b0);
    applyStimulus("inj_d", 1'b1, 1'b0);
    checkOutput("inj_d_state", 32'(state), 32'h0000_0031);
    checkOutput("inj_plen", 32'(period_len), 32'd255);

    // Reset overrides a concurrent load and error request
    div = 16'd0;
    for (int i = 0; i < 3; i++) applyStimulus("pre_rst", 1'b1, 1'b0);
    rst = 1'b1; load = 1'b1; seed = 8'h01; inject_err = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mrst_state", 32'(state), 32'h0000_00FF);
    checkOutput("mrst_prbs", 32'(prbs), 32'd1);
    checkOutput("mrst_valid", 32'(prbs_valid), 32'd0);
    checkOutput("mrst_pstart", 32'(period_start), 32'd0);
    checkOutput("mrst_plen", 32'(period_len), 32'd0);
    m_state = 8'hFF; m_ref = 8'hFF; m_prbs = 1'b1;
    rst = 1'b0; load = 1'b0; inject_err = 1'b0;
    applyStimulus("post_rst", 1'b1, 1'b0);
    checkOutput("post_rst_state", 32'(state), 32'h0000_00E3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
